// File: rtl/mips_pkg.sv
// Shared CPU definitions: memory opcodes and the load-type code carried into W.
package mips_pkg;

    localparam logic [5:0] OP_LW  = 6'b100011;
    localparam logic [5:0] OP_LH  = 6'b100001;
    localparam logic [5:0] OP_LHU = 6'b100101;
    localparam logic [5:0] OP_LB  = 6'b100000;
    localparam logic [5:0] OP_LBU = 6'b100100;
    localparam logic [5:0] OP_SW  = 6'b101011;
    localparam logic [5:0] OP_SH  = 6'b101001;
    localparam logic [5:0] OP_SB  = 6'b101000;

    typedef enum logic [2:0] {
        LD_NONE = 3'd0,
        LD_W    = 3'd1,
        LD_H    = 3'd2,
        LD_HU   = 3'd3,
        LD_B    = 3'd4,
        LD_BU   = 3'd5
    } ld_type_e;

endpackage

// File: rtl/load_ext.sv
// Combinational load-result extraction: lane select plus sign/zero extension.
module load_ext
    import mips_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  off,
    input  ld_type_e    ld_type,
    output logic [31:0] result_c
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = word[7:0];
        case (off)
            2'd1:    byte_sel = word[15:8];
            2'd2:    byte_sel = word[23:16];
            2'd3:    byte_sel = word[31:24];
            default: byte_sel = word[7:0];
        endcase
        half_sel = off[1] ? word[31:16] : word[15:0];

        result_c = '0;
        case (ld_type)
            LD_W:    result_c = word;
            LD_H:    result_c = {{16{half_sel[15]}}, half_sel};
            LD_HU:   result_c = {16'h0000, half_sel};
            LD_B:    result_c = {{24{byte_sel[7]}}, byte_sel};
            LD_BU:   result_c = {24'h000000, byte_sel};
            default: result_c = '0;
        endcase
    end

endmodule

// File: rtl/dm_stage.sv
// Data-memory pipeline stage: byte-enabled stores, registered loads, error flag
// for misaligned or out-of-range accesses, result aligned with MEM/WB.
module dm_stage
    import mips_pkg::*;
#(
    parameter int unsigned WORDS = 1024,
    parameter int unsigned AW    = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] Instr_M,
    input  logic [31:0] ALU_M,
    input  logic [31:0] RT_M,
    input  logic [31:0] PC8_M,
    output logic [31:0] DMout_W,
    output logic        DMerr_W
);

    logic [31:0] mem [WORDS];

    logic [5:0]    opc;
    logic [AW-1:0] idx;
    logic [1:0]    off;
    logic          oor;
    logic          mis;
    logic          bad;
    logic          st_ok;
    logic          ld_ok;
    ld_type_e      ld_d;
    logic [3:0]    be;
    logic [31:0]   wdata;
    logic [31:0]   merged;

    logic [31:0]   word_q;
    ld_type_e      ld_q;
    logic [1:0]    off_q;
    logic          err_q;

    // Only the opcode field matters here
    logic unused_instr;
    assign unused_instr = ^Instr_M[25:0];

    // Decode, access checks and byte-enable merge
    always_comb begin
        opc   = Instr_M[31:26];
        idx   = ALU_M[AW+1:2];
        off   = ALU_M[1:0];
        oor   = |ALU_M[31:AW+2];
        mis   = 1'b0;
        ld_d  = LD_NONE;
        be    = 4'b0000;
        wdata = RT_M;
        case (opc)
            OP_LW:  begin ld_d = LD_W;  mis = |off;   end
            OP_LH:  begin ld_d = LD_H;  mis = off[0]; end
            OP_LHU: begin ld_d = LD_HU; mis = off[0]; end
            OP_LB:  ld_d = LD_B;
            OP_LBU: ld_d = LD_BU;
            OP_SW:  begin be = 4'b1111; mis = |off; end
            OP_SH: begin
                be    = off[1] ? 4'b1100 : 4'b0011;
                wdata = {2{RT_M[15:0]}};
                mis   = off[0];
            end
            OP_SB: begin
                be    = 4'b0001 << off;
                wdata = {4{RT_M[7:0]}};
            end
            default: ;
        endcase

        bad   = ((ld_d != LD_NONE) || (be != 4'b0000)) && (oor || mis);
        st_ok = (be != 4'b0000) && !bad;
        ld_ok = (ld_d != LD_NONE) && !bad;

        merged = mem[idx];
        for (int b = 0; b < 4; b++) begin
            if (be[b]) merged[8*b +: 8] = wdata[8*b +: 8];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int unsigned i = 0; i < WORDS; i++) mem[i] <= '0;
        end else if (st_ok) begin
            mem[idx] <= merged;
        end
    end

    // W-side registers; a rejected or non-load access leaves LD_NONE so the result reads 0
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            word_q <= '0;
            ld_q   <= LD_NONE;
            off_q  <= 2'b00;
            err_q  <= 1'b0;
        end else begin
            word_q <= ld_ok ? mem[idx] : 32'h0000_0000;
            ld_q   <= ld_ok ? ld_d : LD_NONE;
            off_q  <= ld_ok ? off : 2'b00;
            err_q  <= bad;
        end
    end

    load_ext u_load_ext (
        .word     (word_q),
        .off      (off_q),
        .ld_type  (ld_q),
        .result_c (DMout_W)
    );

    assign DMerr_W = err_q;

`ifndef SYNTHESIS
    always @(posedge clk) begin
        if (reset && st_ok)
            $display("%d@%h: *%h <= %h", $time, PC8_M - 32'd8, {ALU_M[31:2], 2'b00}, merged);
    end
`endif

endmodule
